// File: rtl/fft8_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fft8_pkg
// Purpose : Shared definitions for the 8-point sequential FFT: default sample
//           and twiddle widths, FSM state encoding, twiddle ROM and the 3-bit
//           bit-reversal helper.
// Revision: 1.0 - initial release
// ============================================================================
package fft8_pkg;

  localparam int DW      = 12;  // sample width per component
  localparam int TW      = 9;   // twiddle width, signed Q1.7
  localparam int TW_FRAC = 7;   // fractional bits of a twiddle
  localparam int NBFLY   = 12;  // butterflies per frame (3 stages x 4)

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  // W^k = exp(-j*2*pi*k/8) in Q1.7, real part
  function automatic logic signed [TW-1:0] tw_re(input logic [1:0] k);
    case (k)
      2'd0:    return 9'sd128;
      2'd1:    return 9'sd91;
      2'd2:    return 9'sd0;
      default: return -9'sd91;
    endcase
  endfunction

  // W^k imaginary part
  function automatic logic signed [TW-1:0] tw_im(input logic [1:0] k);
    case (k)
      2'd0:    return 9'sd0;
      2'd1:    return -9'sd91;
      2'd2:    return -9'sd128;
      default: return -9'sd91;
    endcase
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft8_bfly.sv
`default_nettype none
// ============================================================================
// Module  : fft8_bfly
// Purpose : Combinational radix-2 DIT butterfly.
//           t = W * bot ; top' = top + t ; bot' = top - t
//           Each partial product is full width, arithmetic-shifted by the
//           twiddle fraction and truncated to DW; all sums wrap mod 2^DW.
// Ports   : top_re_i/top_im_i, bot_re_i/bot_im_i : operands (DW, signed)
//           w_re_i/w_im_i                       : twiddle (TW, signed Q1.7)
//           top_re_o/top_im_o, bot_re_o/bot_im_o : results (DW, signed)
// Revision: 1.0 - initial release
// ============================================================================
module fft8_bfly #(
  parameter int DW = fft8_pkg::DW,
  parameter int TW = fft8_pkg::TW
) (
  input  logic signed [DW-1:0] top_re_i,
  input  logic signed [DW-1:0] top_im_i,
  input  logic signed [DW-1:0] bot_re_i,
  input  logic signed [DW-1:0] bot_im_i,
  input  logic signed [TW-1:0] w_re_i,
  input  logic signed [TW-1:0] w_im_i,
  output logic signed [DW-1:0] top_re_o,
  output logic signed [DW-1:0] top_im_o,
  output logic signed [DW-1:0] bot_re_o,
  output logic signed [DW-1:0] bot_im_o
);
  import fft8_pkg::*;

  localparam int PW = DW + TW;

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DW-1:0] t_re, t_im;

  assign p_rr = PW'(bot_re_i) * PW'(w_re_i);
  assign p_ii = PW'(bot_im_i) * PW'(w_im_i);
  assign p_ri = PW'(bot_re_i) * PW'(w_im_i);
  assign p_ir = PW'(bot_im_i) * PW'(w_re_i);

  // Each product is rescaled on its own before the complex sum.
  assign t_re = DW'(p_rr >>> TW_FRAC) - DW'(p_ii >>> TW_FRAC);
  assign t_im = DW'(p_ri >>> TW_FRAC) + DW'(p_ir >>> TW_FRAC);

  assign top_re_o = top_re_i + t_re;
  assign top_im_o = top_im_i + t_im;
  assign bot_re_o = top_re_i - t_re;
  assign bot_im_o = top_im_i - t_im;

endmodule
`default_nettype wire

// File: rtl/fft8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fft8_seq_ctrl
// Purpose : 8-point radix-2 DIT FFT using one shared butterfly over an
//           8-entry complex register file. LOAD accepts 8 samples into
//           bit-reversed addresses, COMPUTE runs 12 butterflies (one per
//           cycle) plus one transition cycle, OUTPUT streams bins 0..7.
// Ports   : clk, rst (sync, active high)
//           in_valid/in_ready, in_re/in_im   : sample input stream
//           out_valid/out_ready, out_re/out_im, out_idx : result stream
//           busy : high in COMPUTE and OUTPUT
// Revision: 1.0 - initial release
// ============================================================================
module fft8_seq_ctrl #(
  parameter int DW = fft8_pkg::DW,
  parameter int TW = fft8_pkg::TW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic [2:0]    out_idx,
  output logic          busy
);
  import fft8_pkg::*;

  state_t     state_q, state_d;
  // Shared counter: sample index in LOAD, butterfly index in COMPUTE,
  // output bin in OUTPUT.
  logic [3:0] cnt_q, cnt_d;

  logic signed [DW-1:0] re_q [8];
  logic signed [DW-1:0] im_q [8];

  logic                 in_fire;
  logic                 bfly_en;
  logic [1:0]           b;
  logic [2:0]           top_a, bot_a;
  logic [1:0]           k;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [DW-1:0] bt_re, bt_im, bb_re, bb_im;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == 4'd7) begin
            state_d = ST_COMPUTE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        // cnt 0..11 are butterflies; cnt 12 is the idle transition cycle
        if (cnt_q == 4'(NBFLY)) begin
          state_d = ST_OUTPUT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt_q == 4'd7) begin
            state_d = ST_LOAD;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign in_fire = in_valid && in_ready;
  assign bfly_en = (state_q == ST_COMPUTE) && (cnt_q[3:2] != 2'b11);

  // --------------------------------------------------------------------------
  // Butterfly address generation: stage = cnt[3:2], butterfly = cnt[1:0]
  // --------------------------------------------------------------------------
  assign b = cnt_q[1:0];

  always_comb begin
    top_a = 3'd0;
    bot_a = 3'd0;
    k     = 2'd0;
    case (cnt_q[3:2])
      2'd0: begin  // span 1, twiddle always W0
        top_a = {b, 1'b0};
        bot_a = {b, 1'b1};
        k     = 2'd0;
      end
      2'd1: begin  // span 2, pos = b[0], twiddle W0/W2
        top_a = {b[1], 1'b0, b[0]};
        bot_a = {b[1], 1'b1, b[0]};
        k     = {b[0], 1'b0};
      end
      default: begin  // span 4, pos = b, twiddle W0..W3
        top_a = {1'b0, b};
        bot_a = {1'b1, b};
        k     = b;
      end
    endcase
  end

  assign w_re = TW'(tw_re(k));
  assign w_im = TW'(tw_im(k));

  fft8_bfly #(
    .DW (DW),
    .TW (TW)
  ) u_bfly (
    .top_re_i (re_q[top_a]),
    .top_im_i (im_q[top_a]),
    .bot_re_i (re_q[bot_a]),
    .bot_im_i (im_q[bot_a]),
    .w_re_i   (w_re),
    .w_im_i   (w_im),
    .top_re_o (bt_re),
    .top_im_o (bt_im),
    .bot_re_o (bb_re),
    .bot_im_o (bb_im)
  );

  // --------------------------------------------------------------------------
  // Register file (contents survive reset; the frame is discarded by the FSM)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && in_fire) begin
      re_q[bitrev3(cnt_q[2:0])] <= in_re;
      im_q[bitrev3(cnt_q[2:0])] <= in_im;
    end else if (!rst && bfly_en) begin
      re_q[top_a] <= bt_re;
      im_q[top_a] <= bt_im;
      re_q[bot_a] <= bb_re;
      im_q[bot_a] <= bb_im;
    end
  end

  // --------------------------------------------------------------------------
  // Result port: the register file is not written in OUTPUT, so the read
  // stays stable under backpressure.
  // --------------------------------------------------------------------------
  always_comb begin
    out_re  = '0;
    out_im  = '0;
    out_idx = 3'd0;
    if (state_q == ST_OUTPUT) begin
      out_re  = re_q[cnt_q[2:0]];
      out_im  = im_q[cnt_q[2:0]];
      out_idx = cnt_q[2:0];
    end
  end

endmodule
`default_nettype wire

// File: doc/fft8_seq_ctrl.md
FFT8_SEQ_CTRL -- requirements
Module: fft8_seq_ctrl

Interface
REQ-001 SHALL have parameter DW, default 12, meaning sample width per real/imag component (two's complement).
REQ-002 SHALL have parameter TW, default 9, meaning twiddle width, signed Q1.7.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input sample valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts a sample.
REQ-007 SHALL have ports in_re and in_im, input, DW each, input sample.
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have ports out_re and out_im, output, DW each, result X[out_idx].
REQ-011 SHALL have port out_idx, output, 3, frequency bin of current result.
REQ-012 SHALL have port busy, output, 1, high in COMPUTE and OUTPUT.

Function
REQ-013 SHALL implement 8-point radix-2 DIT FFT on one shared butterfly over an 8-entry complex register file.
REQ-014 SHALL use FSM states LOAD, COMPUTE, OUTPUT: LOAD->COMPUTE after the 8th accepted sample; COMPUTE->OUTPUT after the 12th butterfly; OUTPUT->LOAD after the handshake for idx 7.
REQ-015 SHALL assert in_ready only in LOAD; a sample transfers when in_valid&&in_ready; gaps in in_valid are allowed.
REQ-016 SHALL write the n-th accepted sample (n=0..7) to address bitrev3(n).
REQ-017 SHALL execute one butterfly per cycle in COMPUTE, 12 cycles total: stage s=0..2, butterfly b=0..3; span=1<<s; pos=b&(span-1); top=(b>>s)*2*span+pos; bot=top+span; twiddle k=pos<<(2-s).
REQ-018 SHALL compute t=W[k]*R[bot] and write R[top]=R[top]+t, R[bot]=R[top]-t in the same cycle.
REQ-019 SHALL use twiddles (re,im): W0=(128,0), W1=(91,-91), W2=(0,-128), W3=(-91,-91).
REQ-020 SHALL form each 21-bit product, arithmetic-shift it right 7, and truncate to DW bits; complex sums SHALL wrap modulo 2^DW with no scaling or saturation.
REQ-021 SHALL present results in OUTPUT in natural order, idx 0..7, from address idx; out_valid=1 throughout OUTPUT.
REQ-022 SHALL hold out_re, out_im and out_idx stable while out_valid&&!out_ready.
REQ-023 SHALL keep latency from the 8th input handshake to the first out_valid at exactly 13 cycles (12 compute cycles plus 1 state-transition cycle).
REQ-024 SHALL accept no input during COMPUTE/OUTPUT; a new frame starts the cycle after the idx-7 handshake.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter LOAD with counters cleared, in_ready=1, out_valid=0, busy=0, out_idx=0, out_re=0, out_im=0.
REQ-026 SHALL, on reset mid-frame (any state), discard the partial frame; register-file contents need not be cleared.
REQ-027 SHALL give rst priority over a simultaneous handshake.

Structure
REQ-028 SHALL place DW, TW, the twiddle ROM constants, the state enum and the bitrev3 function in shared package fft8_pkg.
REQ-029 SHALL implement the complex multiply-add in one combinational sub-module fft8_bfly (inputs top, bot, twiddle; outputs top', bot').

Verification
REQ-030 SHALL cover impulse: x0=64, others 0 -> all X[k]=(64,0).
REQ-031 SHALL cover DC: all x=(16,0) -> X0=(128,0), X1..X7=(0,0).
REQ-032 SHALL cover real frame x=[64,48,96,128,16,32,80,48] -> X0=(512,0), X4=(0,0), X2=(-96,96), X6=(-96,-96).
REQ-033 SHALL cover backpressure: out_ready low 5 cycles at idx 3 -> idx 3 held stable, no bin skipped or duplicated.
REQ-034 SHALL cover reset during COMPUTE cycle 6 -> next cycle in LOAD, in_ready=1, out_valid=0; the next frame yields correct results.
REQ-035 SHALL cover in_valid toggling every other cycle during LOAD -> exactly 8 samples accepted, first out_valid 13 cycles after the last.
